// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the fetch buffer and its issue-queue handshake.
package fetch_buffer_pkg;

  localparam int FB_WIDTH = 32;
  localparam int IQ_DEPTH = 7;

  typedef enum logic [1:0] {
    WEN_NONE = 2'b00,
    WEN_ONE  = 2'b01,
    WEN_TWO  = 2'b11
  } wen_e;

  // Number of instructions moved by a write-enable pattern.
  function automatic logic [1:0] wen_count(input logic [1:0] wen);
    return {1'b0, wen[0]} + {1'b0, wen[1]};
  endfunction

endpackage

// File: rtl/fb_ptr_ctrl.sv
// Head/tail/count bookkeeping for the fetch buffer, plus in_ready and
// issue write-enable generation from registered state.
module fb_ptr_ctrl
  import fetch_buffer_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       in_valid,
  input  logic [2:0]       iq_free,
  output logic             in_ready,
  output logic [1:0]       push_wen,
  output logic [1:0]       out_wen,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_in_ready;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_n_push;
  logic [1:0]       w_n_pop;

  // Ready depends only on registered count, never on this cycle's pop.
  assign w_in_ready = (r_count <= CNT_W'(DEPTH - 2));

  always_comb begin
    w_push = WEN_NONE;
    if (w_in_ready && !flush) begin
      case (in_valid)
        2'b01:   w_push = WEN_ONE;
        2'b11:   w_push = WEN_TWO;
        default: w_push = WEN_NONE;
      endcase
    end
  end

  always_comb begin
    w_pop = WEN_NONE;
    if (!flush) begin
      if (r_count >= CNT_W'(2) && iq_free >= 3'd2)
        w_pop = WEN_TWO;
      else if (r_count >= CNT_W'(1) && iq_free >= 3'd1)
        w_pop = WEN_ONE;
    end
  end

  assign w_n_push = wen_count(w_push);
  assign w_n_pop  = wen_count(w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_n_pop);
      r_tail  <= r_tail + PTR_W'(w_n_push);
      r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(w_n_pop);
    end
  end

  assign in_ready = w_in_ready;
  assign push_wen = w_push;
  assign out_wen  = w_pop;
  assign head     = r_head;
  assign tail     = r_tail;

  a_count_bound : assert property (@(posedge clk) disable iff (reset)
    r_count <= CNT_W'(DEPTH));
  a_no_underflow : assert property (@(posedge clk) disable iff (reset)
    ({1'b0, r_count} + {{CNT_W-1{1'b0}}, w_n_push}) >= {{CNT_W-1{1'b0}}, w_n_pop});

endmodule

// File: rtl/fetch_buffer.sv
// Two-wide in-order fetch buffer: circular entry array with dual read ports
// at head and head+1; pointer control lives in fb_ptr_ctrl.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter  int WIDTH = FB_WIDTH,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_inst0,
  input  logic [WIDTH-1:0] in_inst1,
  input  logic [1:0]       in_valid,
  output logic             in_ready,
  input  logic [2:0]       iq_free,
  output logic [WIDTH-1:0] out_inst0,
  output logic [WIDTH-1:0] out_inst1,
  output logic [1:0]       out_wen
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [1:0]       w_push;
  logic [PTR_W-1:0] w_head;
  logic [PTR_W-1:0] w_tail;
  logic [PTR_W-1:0] w_head_p1;
  logic [PTR_W-1:0] w_tail_p1;

  fb_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .iq_free  (iq_free),
    .in_ready (in_ready),
    .push_wen (w_push),
    .out_wen  (out_wen),
    .head     (w_head),
    .tail     (w_tail)
  );

  // Pointer increments wrap naturally at PTR_W bits, so pairs may straddle.
  assign w_head_p1 = w_head + PTR_W'(1);
  assign w_tail_p1 = w_tail + PTR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push[0]) r_mem[w_tail]    <= in_inst0;
      if (w_push[1]) r_mem[w_tail_p1] <= in_inst1;
    end
  end

  assign out_inst0 = r_mem[w_head];
  assign out_inst1 = r_mem[w_head_p1];

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer: reset, streaming,
// backpressure, partial issue, wrap-around and flush collision.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] in_inst0;
  logic [31:0] in_inst1;
  logic [1:0]  in_valid;
  logic        in_ready;
  logic [2:0]  iq_free;
  logic [31:0] out_inst0;
  logic [31:0] out_inst1;
  logic [1:0]  out_wen;

  int checks = 0;
  int errors = 0;

  fetch_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_inst0  (in_inst0),
    .in_inst1  (in_inst1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .iq_free   (iq_free),
    .out_inst0 (out_inst0),
    .out_inst1 (out_inst1),
    .out_wen   (out_wen)
  );

  always #5 clk = ~clk;

  a_legal_valid : assert property (@(posedge clk) disable iff (reset) in_valid != 2'b10)
    else begin
      errors++;
      $error("FAIL in_valid_10: observed %b expected not 10", in_valid);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_inst0 = a;
    in_inst1 = b;
  endtask

  function automatic logic [31:0] cnt();
    return 32'(dut.u_ptr.r_count);
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; iq_free = 3'd0;
    drive(2'b00, 32'h0, 32'h0);
    #3;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wen",   32'(out_wen),  32'd0);
    chk("rst_out0",  out_inst0,     32'h0);
    chk("rst_out1",  out_inst1,     32'h0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Reset mid-operation: five entries then async reset between edges
    drive(2'b11, 32'h1, 32'h2); tick();
    drive(2'b11, 32'h3, 32'h4); tick();
    drive(2'b01, 32'h5, 32'h0); tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("mid_count5", cnt(), 32'd5);
    chk("mid_ready5", 32'(in_ready), 32'd1);
    iq_free = 3'd7;
    #1 reset = 1'b1;
    #1;
    chk("arst_count", cnt(), 32'd0);
    chk("arst_wen",   32'(out_wen),  32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_out0",  out_inst0,     32'h0);
    #1 reset = 1'b0;

    // Streaming with iq_free=7
    drive(2'b11, 32'h11, 32'h22);
    #1 chk("strm_nobypass", 32'(out_wen), 32'd0);
    tick();
    drive(2'b11, 32'h33, 32'h44);
    chk("strm1_wen",  32'(out_wen), 32'd3);
    chk("strm1_out0", out_inst0, 32'h11);
    chk("strm1_out1", out_inst1, 32'h22);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("strm2_wen",  32'(out_wen), 32'd3);
    chk("strm2_out0", out_inst0, 32'h33);
    chk("strm2_out1", out_inst1, 32'h44);
    tick();
    chk("strm_empty", 32'(out_wen), 32'd0);

    // Backpressure: fill to 8, fifth pair dropped
    iq_free = 3'd0;
    drive(2'b11, 32'hA0, 32'hA1); tick();
    drive(2'b11, 32'hA2, 32'hA3); tick();
    drive(2'b11, 32'hA4, 32'hA5); tick();
    drive(2'b11, 32'hA6, 32'hA7); tick();
    chk("bp_count8", cnt(), 32'd8);
    chk("bp_ready0", 32'(in_ready), 32'd0);
    drive(2'b11, 32'hEE, 32'hEF); tick();
    chk("bp_drop_cnt", cnt(), 32'd8);
    drive(2'b00, 32'h0, 32'h0);
    iq_free = 3'd1;
    #1;
    chk("bp_wen1a", 32'(out_wen), 32'd1);
    chk("bp_out_a0", out_inst0, 32'hA0);
    tick();
    chk("bp_count7", cnt(), 32'd7);
    chk("bp_ready7", 32'(in_ready), 32'd0);
    chk("bp_wen1b", 32'(out_wen), 32'd1);
    chk("bp_out_a1", out_inst0, 32'hA1);
    tick();
    chk("bp_count6", cnt(), 32'd6);
    chk("bp_ready6", 32'(in_ready), 32'd1);
    iq_free = 3'd7;
    #1;
    chk("bp_drain_a2", out_inst0, 32'hA2);
    chk("bp_drain_a3", out_inst1, 32'hA3);
    tick();
    chk("bp_drain_a4", out_inst0, 32'hA4);
    chk("bp_drain_a5", out_inst1, 32'hA5);
    tick();
    chk("bp_drain_a6", out_inst0, 32'hA6);
    chk("bp_drain_a7", out_inst1, 32'hA7);
    tick();
    chk("bp_empty_cnt", cnt(), 32'd0);
    chk("bp_empty_wen", 32'(out_wen), 32'd0);

    // Partial issue
    iq_free = 3'd0;
    drive(2'b11, 32'hC1, 32'hC2); tick();
    drive(2'b01, 32'hC3, 32'h0);  tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("pi_count3", cnt(), 32'd3);
    iq_free = 3'd1;
    #1;
    chk("pi_wen1", 32'(out_wen), 32'd1);
    chk("pi_out_c1", out_inst0, 32'hC1);
    tick();
    chk("pi_count2", cnt(), 32'd2);
    iq_free = 3'd2;
    #1;
    chk("pi_wen2", 32'(out_wen), 32'd3);
    chk("pi_out_c2", out_inst0, 32'hC2);
    chk("pi_out_c3", out_inst1, 32'hC3);
    tick();
    chk("pi_count0", cnt(), 32'd0);
    chk("pi_head7", 32'(dut.u_ptr.r_head), 32'd7);

    // Wrap-around: pair straddles entries 7 and 0
    iq_free = 3'd0;
    drive(2'b11, 32'hA, 32'hB); tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("wr_count2", cnt(), 32'd2);
    iq_free = 3'd7;
    #1;
    chk("wr_wen", 32'(out_wen), 32'd3);
    chk("wr_out0", out_inst0, 32'hA);
    chk("wr_out1", out_inst1, 32'hB);
    tick();
    chk("wr_head1", 32'(dut.u_ptr.r_head), 32'd1);

    // Flush collision with push and pop
    iq_free = 3'd0;
    drive(2'b11, 32'h61, 32'h62); tick();
    drive(2'b11, 32'h63, 32'h64); tick();
    chk("fl_count4", cnt(), 32'd4);
    drive(2'b11, 32'h71, 32'h72);
    iq_free = 3'd7;
    flush = 1'b1;
    #1;
    chk("fl_wen0", 32'(out_wen), 32'd0);
    tick();
    flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    chk("fl_count0", cnt(), 32'd0);
    chk("fl_head0", 32'(dut.u_ptr.r_head), 32'd0);
    chk("fl_wen_post", 32'(out_wen), 32'd0);
    drive(2'b01, 32'h81, 32'h0);
    #1 chk("fl_push_nobyp", 32'(out_wen), 32'd0);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    chk("fl_first_wen", 32'(out_wen), 32'd1);
    chk("fl_first_out", out_inst0, 32'h81);
    tick();
    chk("fl_final_cnt", cnt(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
